// File: rtl/jt900h_busarb.sv
// Arbitrates one memory port between the CPU and a DMA requester.
// The DMA may take up to MAXBURST accesses before the CPU gets one slot.
module jt900h_busarb #(
    parameter int MAXBURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_dout,
    output logic        cpu_cen,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic [15:0] dma_din,
    input  logic [1:0]  dma_we,
    output logic        dma_ack,
    output logic [15:0] dma_dout,
    output logic        mem_cs,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_we,
    input  logic [15:0] mem_dout,
    input  logic        mem_ok,
    output logic        dma_owner
);

    typedef enum logic [1:0] {
        RUN0 = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  burst_q, burst_d;
    logic [15:0] dout_q, dout_d;
    logic [2:0]  burst_inc;
    logic        done;

    // mem_ok only counts on enabled cycles; memory holds it until then
    assign done      = cen & mem_ok;
    assign burst_inc = (burst_q == 3'd7) ? burst_q : burst_q + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN0;
            burst_q <= 3'd0;
            dout_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        dout_d    = dout_q;
        mem_cs    = 1'b0;
        mem_addr  = cpu_addr;
        mem_din   = cpu_din;
        mem_we    = 2'b00;
        cpu_cen   = 1'b0;
        dma_ack   = 1'b0;
        dma_owner = 1'b0;
        unique case (state_q)
            RUN0: begin
                if (cen) state_d = CPU;
            end
            CPU: begin
                mem_cs  = 1'b1;
                mem_we  = cpu_we;
                cpu_cen = done;
                if (done && dma_req) begin
                    state_d = DMA;
                    burst_d = 3'd0;
                end
            end
            DMA: begin
                mem_cs    = 1'b1;
                mem_addr  = dma_addr;
                mem_din   = dma_din;
                mem_we    = dma_we;
                dma_owner = 1'b1;
                dma_ack   = done;
                if (done) begin
                    dout_d  = mem_dout;
                    burst_d = burst_inc;
                    if (dma_req && burst_inc < 3'(MAXBURST))
                        state_d = DMA;
                    else
                        state_d = CPU;
                end
            end
            default: state_d = RUN0;
        endcase
    end

    assign cpu_dout = mem_dout;
    assign dma_dout = dout_q;

endmodule
